inst_fetch: RTL and testbench

//   Fetch-side requester for the instruction memory read port (re/raddr/rdata, combinational read).

---
 rtl/cpu_pkg.sv | 14 +
 rtl/inst_fetch.sv | 124 ++++++++++++
 tb/tb_inst_fetch.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch FSM encoding and default reset PC.
package cpu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_RUN  = 2'd1,
      FS_HALT = 2'd2
   } fetch_state_t;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, IDLE/RUN/HALT control and the IF/ID stage register.
// Handshake toward decode: an entry transfers on a rising edge where if_valid && id_ready.
module inst_fetch
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              ADDR_W   = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt_req,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              imem_re,
   output logic [ADDR_W-1:0] imem_raddr,
   input  logic [XLEN-1:0]   imem_rdata,
   output logic              if_valid,
   output logic [XLEN-1:0]   if_pc,
   output logic [XLEN-1:0]   if_inst,
   input  logic              id_ready,
   output logic              fault,
   output logic [1:0]        state
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic [XLEN-1:0] if_inst_q, if_inst_d;
   logic            fault_q, fault_d;

   logic fire;
   logic consume;
   logic redir_bad;

   // An address is reachable only if every bit above the word index is zero.
   function automatic logic in_range(input logic [XLEN-1:0] a);
      return (a >> (ADDR_W + 2)) == '0;
   endfunction

   function automatic logic aligned(input logic [XLEN-1:0] a);
      return a[1:0] == 2'b00;
   endfunction

   always_comb begin
      redir_bad = redirect_valid && !(aligned(redirect_pc) && in_range(redirect_pc));
      consume   = if_valid_q && id_ready;
      fire      = (state_q == FS_RUN) && !halt_req && !redirect_valid && in_range(pc_q)
                  && (!if_valid_q || id_ready);
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      fault_d    = fault_q;
      case (state_q)
         FS_IDLE: begin
            if (redir_bad) begin
               fault_d = 1'b1;
               state_d = FS_HALT;
            end else begin
               if (redirect_valid) pc_d = redirect_pc;
               if (start) state_d = FS_RUN;
            end
         end
         FS_RUN: begin
            if (redir_bad || (!redirect_valid && !in_range(pc_q))) begin
               fault_d    = 1'b1;
               state_d    = FS_HALT;
               if_valid_d = 1'b0;
            end else if (halt_req) begin
               // A pending entry survives the halt and drains normally.
               state_d = FS_HALT;
               if (consume) if_valid_d = 1'b0;
            end else if (redirect_valid) begin
               pc_d       = redirect_pc;
               if_valid_d = 1'b0;
            end else if (fire) begin
               if_inst_d  = imem_rdata;
               if_pc_d    = pc_q;
               if_valid_d = 1'b1;
               pc_d       = pc_q + 32'd4;
            end else if (consume) begin
               if_valid_d = 1'b0;
            end
         end
         FS_HALT: begin
            if (consume) if_valid_d = 1'b0;
         end
         default: state_d = FS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FS_IDLE;
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_inst_q  <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
         fault_q    <= fault_d;
      end
   end

   assign imem_re    = fire;
   assign imem_raddr = pc_q[ADDR_W+1:2];
   assign if_valid   = if_valid_q;
   assign if_pc      = if_pc_q;
   assign if_inst    = if_inst_q;
   assign fault      = fault_q;
   assign state      = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a 1K-word instance for the main flow and a 16-word
// instance for the address-range run-off case.
module tb_inst_fetch;
   import cpu_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // ---------------- instance A (ADDR_W = 10) ----------------
   logic        start, halt_req, redirect_valid, id_ready;
   logic [31:0] redirect_pc;
   logic        imem_re;
   logic [9:0]  imem_raddr;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc, if_inst;
   logic        fault;
   logic [1:0]  state;
   logic [31:0] mem_a [1024];

   assign imem_rdata = mem_a[imem_raddr];

   inst_fetch #(.RESET_PC(32'h0), .ADDR_W(10)) dut_a (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_re(imem_re), .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready),
      .fault(fault), .state(state)
   );

   // ---------------- instance B (ADDR_W = 4) ----------------
   logic        b_start, b_halt_req, b_redirect_valid, b_id_ready;
   logic [31:0] b_redirect_pc;
   logic        b_imem_re;
   logic [3:0]  b_imem_raddr;
   logic [31:0] b_imem_rdata;
   logic        b_if_valid;
   logic [31:0] b_if_pc, b_if_inst;
   logic        b_fault;
   logic [1:0]  b_state;
   logic [31:0] mem_b [16];

   assign b_imem_rdata = mem_b[b_imem_raddr];

   inst_fetch #(.RESET_PC(32'h0), .ADDR_W(4)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .halt_req(b_halt_req),
      .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
      .imem_re(b_imem_re), .imem_raddr(b_imem_raddr), .imem_rdata(b_imem_rdata),
      .if_valid(b_if_valid), .if_pc(b_if_pc), .if_inst(b_if_inst), .id_ready(b_id_ready),
      .fault(b_fault), .state(b_state)
   );

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      for (int i = 0; i < 1024; i++) mem_a[i] = 32'hA000_0000 + 32'(i);
      mem_a[0] = 32'h11; mem_a[1] = 32'h22; mem_a[2] = 32'h33; mem_a[3] = 32'h44;
      for (int i = 0; i < 16; i++) mem_b[i] = 32'hB000_0000 + 32'(i);

      start = 0; halt_req = 0; redirect_valid = 0; redirect_pc = 0; id_ready = 0;
      b_start = 0; b_halt_req = 0; b_redirect_valid = 0; b_redirect_pc = 0; b_id_ready = 0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_if_inst", if_inst, 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_state", 32'(state), 32'(FS_IDLE));
      chk("rst_imem_re", 32'(imem_re), 32'd0);
      tick(); tick();
      #2 rst = 1'b1;
      tick();
      chk("idle_raddr", 32'(imem_raddr), 32'd0);
      chk("idle_re", 32'(imem_re), 32'd0);

      // 1: start, stream 0,4,...
      start = 1; id_ready = 1;
      tick();
      start = 0; #1;
      chk("t1_state_run", 32'(state), 32'(FS_RUN));
      chk("t1_no_valid_yet", 32'(if_valid), 32'd0);
      chk("t1_re", 32'(imem_re), 32'd1);
      chk("t1_raddr0", 32'(imem_raddr), 32'd0);
      tick();
      chk("t1_v0", 32'(if_valid), 32'd1);
      chk("t1_pc0", if_pc, 32'h0);
      chk("t1_inst0", if_inst, 32'h11);
      tick();
      chk("t1_pc4", if_pc, 32'h4);
      chk("t1_inst4", if_inst, 32'h22);

      // 2: backpressure for three cycles
      id_ready = 0; #1;
      chk("t2_re_stall", 32'(imem_re), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t2_hold_v", 32'(if_valid), 32'd1);
         chk("t2_hold_pc", if_pc, 32'h4);
         chk("t2_hold_inst", if_inst, 32'h22);
         chk("t2_hold_re", 32'(imem_re), 32'd0);
      end
      id_ready = 1; #1;
      chk("t2_release_re", 32'(imem_re), 32'd1);
      chk("t2_release_raddr", 32'(imem_raddr), 32'd2);
      tick();
      chk("t2_pc8", if_pc, 32'h8);
      chk("t2_inst8", if_inst, 32'h33);
      tick();
      chk("t1_pcC", if_pc, 32'hC);
      chk("t1_instC", if_inst, 32'h44);

      // 3: redirect squashes the pending entry
      redirect_valid = 1; redirect_pc = 32'h40; #1;
      chk("t3_re_redirect", 32'(imem_re), 32'd0);
      tick();
      chk("t3_squash", 32'(if_valid), 32'd0);
      redirect_valid = 0; #1;
      chk("t3_re", 32'(imem_re), 32'd1);
      chk("t3_raddr", 32'(imem_raddr), 32'h10);
      tick();
      chk("t3_v", 32'(if_valid), 32'd1);
      chk("t3_pc", if_pc, 32'h40);
      chk("t3_inst", if_inst, 32'hA000_0010);

      // 6: halt beats redirect; pending entry drains later
      id_ready = 0; halt_req = 1; redirect_valid = 1; redirect_pc = 32'h80; #1;
      chk("t6_re", 32'(imem_re), 32'd0);
      tick();
      chk("t6_state", 32'(state), 32'(FS_HALT));
      chk("t6_v_held", 32'(if_valid), 32'd1);
      chk("t6_pc_held", if_pc, 32'h40);
      chk("t6_no_redirect", 32'(imem_raddr), 32'h11);
      halt_req = 0; redirect_valid = 0; start = 1;
      tick();
      chk("t6_v_still", 32'(if_valid), 32'd1);
      chk("t6_state_still", 32'(state), 32'(FS_HALT));
      id_ready = 1;
      tick();
      chk("t6_drained", 32'(if_valid), 32'd0);
      chk("t6_state_end", 32'(state), 32'(FS_HALT));
      chk("t6_re_end", 32'(imem_re), 32'd0);
      start = 0;

      // 7: reset, legal redirect in IDLE, run, then async reset mid-run
      rst = 0; #1;
      chk("t7_state_idle", 32'(state), 32'(FS_IDLE));
      rst = 1;
      redirect_valid = 1; redirect_pc = 32'h20;
      tick();
      chk("t7_idle_redir_state", 32'(state), 32'(FS_IDLE));
      chk("t7_idle_redir_raddr", 32'(imem_raddr), 32'h8);
      chk("t7_idle_redir_v", 32'(if_valid), 32'd0);
      redirect_valid = 0; start = 1;
      tick();
      start = 0;
      tick();
      chk("t7_pc20", if_pc, 32'h20);
      chk("t7_inst20", if_inst, 32'hA000_0008);
      tick();
      chk("t7_pc24", if_pc, 32'h24);
      #2 rst = 0;
      #1;
      chk("t7_async_v", 32'(if_valid), 32'd0);
      chk("t7_async_pc", if_pc, 32'd0);
      chk("t7_async_inst", if_inst, 32'd0);
      chk("t7_async_state", 32'(state), 32'(FS_IDLE));
      chk("t7_async_re", 32'(imem_re), 32'd0);
      chk("t7_async_raddr", 32'(imem_raddr), 32'd0);
      #1 rst = 1;
      tick();
      chk("t7_post_state", 32'(state), 32'(FS_IDLE));
      start = 1;
      tick();
      start = 0;
      tick();
      chk("t7_resume_pc", if_pc, 32'h0);
      chk("t7_resume_inst", if_inst, 32'h11);

      // 4: misaligned redirect faults; later start/redirect ignored
      redirect_valid = 1; redirect_pc = 32'h42;
      tick();
      chk("t4_fault", 32'(fault), 32'd1);
      chk("t4_state", 32'(state), 32'(FS_HALT));
      chk("t4_v", 32'(if_valid), 32'd0);
      chk("t4_pc_kept", 32'(imem_raddr), 32'd1);
      redirect_pc = 32'h100; start = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_halt_state", 32'(state), 32'(FS_HALT));
         chk("t4_halt_re", 32'(imem_re), 32'd0);
         chk("t4_halt_raddr", 32'(imem_raddr), 32'd1);
         chk("t4_sticky", 32'(fault), 32'd1);
      end
      redirect_valid = 0; start = 0;

      // 5: small memory runs off the end at 0x40
      b_redirect_valid = 1; b_redirect_pc = 32'h38;
      tick();
      chk("t5_idle_state", 32'(b_state), 32'(FS_IDLE));
      chk("t5_raddr", 32'(b_imem_raddr), 32'hE);
      b_redirect_valid = 0; b_start = 1; b_id_ready = 1;
      tick();
      b_start = 0; #1;
      chk("t5_run", 32'(b_state), 32'(FS_RUN));
      chk("t5_re", 32'(b_imem_re), 32'd1);
      tick();
      chk("t5_pc38", b_if_pc, 32'h38);
      chk("t5_inst38", b_if_inst, 32'hB000_000E);
      tick();
      chk("t5_pc3C", b_if_pc, 32'h3C);
      chk("t5_inst3C", b_if_inst, 32'hB000_000F);
      chk("t5_no_fetch40", 32'(b_imem_re), 32'd0);
      chk("t5_fault_not_yet", 32'(b_fault), 32'd0);
      tick();
      chk("t5_fault", 32'(b_fault), 32'd1);
      chk("t5_halt", 32'(b_state), 32'(FS_HALT));
      chk("t5_v", 32'(b_if_valid), 32'd0);
      chk("t5_re_off", 32'(b_imem_re), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
